matrix_mul_seq: RTL and testbench

- Parametrised N x N integer matrix multiplier computing C = A * B.
- Generalises the fixed 2x2 multiplier with configurable dimension, operand width and signed mode.
- Uses a single time-shared multiply-accumulate unit. Operands are captured at start.
- Results appear on a flat output bus and are qualified by a one-cycle done pulse. Used wherever the fully parallel 2x2 block is too small or too large.

---
 rtl/matrix_mul_pkg.sv | 25 ++
 rtl/matrix_mac.sv | 48 ++++
 rtl/matrix_mul_seq.sv | 139 +++++++++++++
 tb/tb_matrix_mul_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the sequential N x N matrix multiplier.
// Holds the FSM state encoding, result-width derivation and flat-bus slicing helpers.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Each result element is a sum of N products of two DW-bit values, so it
  // needs 2*DW bits plus enough headroom for N additions.
  function automatic int calc_accw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  function automatic int elem_lsb(input int r, input int c, input int n, input int w);
    return elem_idx(r, c, n) * w;
  endfunction

endpackage

// File: rtl/matrix_mac.sv
// Time-shared multiply-accumulate unit: one DW x DW product per cycle into an ACCW accumulator.
// The sum output presents acc + product so the final term of a dot product can be stored directly.
module matrix_mac #(
  parameter int DW     = 8,
  parameter int ACCW   = 18,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] sum
);

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] acc;

  // The 2*DW product is exact in both modes, so only the extension differs.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DW-1:0] sa;
      logic signed [2*DW-1:0] sb;
      assign sa       = {{DW{a[DW-1]}}, a};
      assign sb       = {{DW{b[DW-1]}}, b};
      assign prod     = sa * sb;
      assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    end else begin : g_unsigned
      assign prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      assign prod_ext = {{(ACCW-2*DW){1'b0}}, prod};
    end
  endgenerate

  assign sum = acc + prod_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential N x N matrix multiplier C = A * B using a single time-shared MAC.
// Operands are captured on an accepted start; done pulses once c_flat is complete.
module matrix_mul_seq
  import matrix_mul_pkg::*;
#(
  parameter int  N      = 4,
  parameter int  DW     = 8,
  parameter int  SIGNED = 0,
  localparam int ACCW   = calc_accw(DW, N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic [N*N*ACCW-1:0] c_flat,
  output logic                busy,
  output logic                done
);

  localparam int             IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  state_t state, next_state;

  logic [IW-1:0]     i, j, k;
  logic [N*N*DW-1:0] a_reg, b_reg;
  logic [DW-1:0]     a_mat [N][N];
  logic [DW-1:0]     b_mat [N][N];
  logic [ACCW-1:0]   c_mat [N][N];
  logic [ACCW-1:0]   mac_sum;
  logic              accept, k_last, last_mac, mac_clr, mac_en;

  generate
    for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_col
        assign a_mat[r][c] = a_reg[elem_lsb(r, c, N, DW) +: DW];
        assign b_mat[r][c] = b_reg[elem_lsb(r, c, N, DW) +: DW];
        assign c_flat[elem_lsb(r, c, N, ACCW) +: ACCW] = c_mat[r][c];
      end
    end
  endgenerate

  assign accept   = (state == IDLE) && start;
  assign k_last   = (k == LAST);
  assign last_mac = (state == CALC) && k_last && (j == LAST) && (i == LAST);
  assign mac_en   = (state == CALC);
  assign mac_clr  = accept || (mac_en && k_last);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (last_mac) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Row-major walk: k innermost, then j, then i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (accept) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (state == CALC) begin
      if (k_last) begin
        k <= '0;
        if (j == LAST) begin
          j <= '0;
          i <= (i == LAST) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a_flat;
      b_reg <= b_flat;
    end
  end

  matrix_mac #(
    .DW     (DW),
    .ACCW   (ACCW),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_mat[i][k]),
    .b   (b_mat[k][j]),
    .sum (mac_sum)
  );

  // The last MAC of each dot product writes acc + product straight into C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          c_mat[r][c] <= '0;
        end
      end
    end else if (mac_en && k_last) begin
      c_mat[i][j] <= mac_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= last_mac;
    end
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Self-checking bench for matrix_mul_seq: three instances (N=4 unsigned, N=2 unsigned, N=2 signed)
// checked against a plain-arithmetic matrix product model with directed and random operands.
module tb_matrix_mul_seq;

  localparam int ACC4 = 18;
  localparam int ACC2 = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 start4, start2, start2s;
  logic [16*8-1:0]      a4, b4;
  logic [4*8-1:0]       a2, b2, a2s, b2s;
  logic [16*ACC4-1:0]   c4;
  logic [4*ACC2-1:0]    c2, c2s;
  logic                 busy4, busy2, busy2s;
  logic                 done4, done2, done2s;

  matrix_mul_seq #(.N(4), .DW(8), .SIGNED(0)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_flat(a4), .b_flat(b4),
    .c_flat(c4), .busy(busy4), .done(done4));

  matrix_mul_seq #(.N(2), .DW(8), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_flat(a2), .b_flat(b2),
    .c_flat(c2), .busy(busy2), .done(done2));

  matrix_mul_seq #(.N(2), .DW(8), .SIGNED(1)) u_dut2s (
    .clk(clk), .rst(rst), .start(start2s), .a_flat(a2s), .b_flat(b2s),
    .c_flat(c2s), .busy(busy2s), .done(done2s));

  int     checks   = 0;
  int     failures = 0;
  int     ma [16];
  int     mb [16];
  longint exp_c [16];
  longint exp_prev [16];
  int     done_at, busy_cnt, done_cnt, quiet_dones;
  bit     timed_out;

  // Reference: textbook matrix product on plain integers.
  function automatic void model(input int n);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        longint s = 0;
        for (int x = 0; x < n; x++) s += longint'(ma[r*n+x]) * longint'(mb[x*n+c]);
        exp_c[r*n+c] = s;
      end
    end
  endfunction

  function automatic longint mask(input longint v, input int w);
    return v & ((longint'(1) << w) - 1);
  endfunction

  function automatic longint get_c(input int which, input int r, input int c);
    case (which)
      0:       return longint'(c4[(r*4+c)*ACC4 +: ACC4]);
      1:       return longint'(c2[(r*2+c)*ACC2 +: ACC2]);
      default: return longint'(c2s[(r*2+c)*ACC2 +: ACC2]);
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? busy4 : (which == 1) ? busy2 : busy2s;
  endfunction

  function automatic logic get_done(input int which);
    return (which == 0) ? done4 : (which == 1) ? done2 : done2s;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start4  = v;
      1:       start2  = v;
      default: start2s = v;
    endcase
  endtask

  task automatic apply_stimulus(input int which);
    for (int e = 0; e < 16; e++) begin
      case (which)
        0: begin a4[e*8 +: 8] = 8'(ma[e]); b4[e*8 +: 8] = 8'(mb[e]); end
        1: if (e < 4) begin a2[e*8 +: 8] = 8'(ma[e]); b2[e*8 +: 8] = 8'(mb[e]); end
        default: if (e < 4) begin a2s[e*8 +: 8] = 8'(ma[e]); b2s[e*8 +: 8] = 8'(mb[e]); end
      endcase
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_output(input int which, input int n, input int accw,
                              input longint e [16], input string tag);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        check($sformatf("%s c[%0d][%0d]", tag, r, c), get_c(which, r, c), mask(e[r*n+c], accw));
  endtask

  function automatic void randomize_ops(input int n, input bit sgn);
    for (int e = 0; e < n*n; e++) begin
      ma[e] = int'($urandom_range(255)) - (sgn ? 128 : 0);
      mb[e] = int'($urandom_range(255)) - (sgn ? 128 : 0);
    end
  endfunction

  // One start pulse, then observe until busy drops; m counts edges after the start edge.
  task automatic run_op(input int which, input int n, input bit repulse);
    int m = 0;
    int budget = n*n*n + 20;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    done_at = -1; busy_cnt = 0; done_cnt = 0;
    while (get_busy(which) && m < budget) begin
      busy_cnt++;
      if (repulse && (m == 3 || m == n*n*n)) set_start(which, 1'b1);
      @(posedge clk); #1;
      m++;
      set_start(which, 1'b0);
      if (get_done(which)) begin
        done_cnt++;
        if (done_at < 0) done_at = m;
      end
    end
    timed_out = (m >= budget);
  endtask

  task automatic check_timing(input string tag, input int n);
    check({tag, " timeout"}, longint'(timed_out), 0);
    check({tag, " done edge"}, done_at, n*n*n);
    check({tag, " busy cycles"}, busy_cnt, n*n*n + 1);
    check({tag, " done count"}, done_cnt, 1);
  endtask

  initial begin
    int first_done, second_done, m;
    rst = 1'b0;
    start4 = 0; start2 = 0; start2s = 0;
    a4 = '0; b4 = '0; a2 = '0; b2 = '0; a2s = '0; b2s = '0;
    #12;
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset c4[3][3]", get_c(0, 3, 3), 0);
    check("reset busy2s", busy2s, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] N=2 unsigned small matrices");
    ma[0:3] = '{1, 2, 3, 4};
    mb[0:3] = '{5, 6, 7, 8};
    model(2); apply_stimulus(1); run_op(1, 2, 0);
    check_timing("n2 small", 2);
    check_output(1, 2, ACC2, exp_c, "n2 small");
    check("n2 small c11 literal", get_c(1, 1, 1), 50);

    $display("[TB] N=2 unsigned all 255");
    for (int e = 0; e < 4; e++) begin ma[e] = 255; mb[e] = 255; end
    model(2); apply_stimulus(1); run_op(1, 2, 0);
    check_output(1, 2, ACC2, exp_c, "n2 max");
    check("n2 max c00 literal", get_c(1, 0, 0), 130050);

    $display("[TB] N=2 signed all -128 and identity");
    for (int e = 0; e < 4; e++) begin ma[e] = -128; mb[e] = -128; end
    model(2); apply_stimulus(2); run_op(2, 2, 0);
    check_timing("n2s min", 2);
    check_output(2, 2, ACC2, exp_c, "n2s min");
    check("n2s min c10 literal", get_c(2, 1, 0), 32768);
    ma[0:3] = '{1, 0, 0, 1};
    mb[0:3] = '{-1, 5, 7, -128};
    model(2); apply_stimulus(2); run_op(2, 2, 0);
    check_output(2, 2, ACC2, exp_c, "n2s ident");

    $display("[TB] N=4 identity with start re-pulsed while busy");
    for (int e = 0; e < 16; e++) begin ma[e] = (e / 4 == e % 4) ? 1 : 0; mb[e] = e; end
    model(4); apply_stimulus(0); run_op(0, 4, 1);
    check_timing("n4 ident", 4);
    check_output(0, 4, ACC4, exp_c, "n4 ident");
    repeat (3) @(posedge clk);
    #1 check("n4 no requeue busy", busy4, 0);

    $display("[TB] random operands");
    for (int t = 0; t < 2; t++) begin
      randomize_ops(4, 0); model(4); apply_stimulus(0); run_op(0, 4, 0);
      check_output(0, 4, ACC4, exp_c, $sformatf("n4 rand%0d", t));
      randomize_ops(2, 1); model(2); apply_stimulus(2); run_op(2, 2, 0);
      check_output(2, 2, ACC2, exp_c, $sformatf("n2s rand%0d", t));
      randomize_ops(2, 0); model(2); apply_stimulus(1); run_op(1, 2, 0);
      check_output(1, 2, ACC2, exp_c, $sformatf("n2 rand%0d", t));
    end

    $display("[TB] reset during CALC");
    randomize_ops(4, 0); apply_stimulus(0);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset busy4", busy4, 0);
    check("midreset done4", done4, 0);
    for (int e = 0; e < 16; e++)
      check($sformatf("midreset c4 elem%0d", e), get_c(0, e / 4, e % 4), 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b1;
    quiet_dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done4 || busy4) quiet_dones++;
    end
    check("post reset no activity", quiet_dones, 0);
    randomize_ops(4, 0); model(4); apply_stimulus(0); run_op(0, 4, 0);
    check_timing("n4 after reset", 4);
    check_output(0, 4, ACC4, exp_c, "n4 after reset");

    $display("[TB] back-to-back with start held high");
    randomize_ops(2, 0); model(2); exp_prev = exp_c; apply_stimulus(1);
    set_start(1, 1'b1);
    @(posedge clk); #1;
    randomize_ops(2, 0); model(2); apply_stimulus(1);
    first_done = -1; second_done = -1; m = 0;
    while (m < 60 && second_done < 0) begin
      @(posedge clk); #1;
      m++;
      if (m == 12) set_start(1, 1'b0);
      if (done2) begin
        if (first_done < 0) begin
          first_done = m;
          check_output(1, 2, ACC2, exp_prev, "b2b first");
        end else begin
          second_done = m;
          check_output(1, 2, ACC2, exp_c, "b2b second");
        end
      end
    end
    set_start(1, 1'b0);
    check("b2b first done edge", first_done, 8);
    check("b2b second done edge", second_done, 18);
    repeat (3) @(posedge clk);
    #1 check("b2b idle after", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
